h264_transform_mb_sequencer: RTL and testbench
==============================================

Name: h264_transform_mb_sequencer

Overview:
Sequences one macroblock of 4x4 residual rows through the 4-stage H.264 core-transform datapath (pipeline stages 2-5). It accepts rows from the residual source over a valid/ready handshake and drives the per-stage enables. It tracks block/row tags alongside the data and presents them with downstream valid/ready backpressure. It replaces free-running enable sequencing with a stall-safe, tag-tracked scheduler that sits between the residual buffer and the quantiser.

Parameters:
PIPE_DEPTH, 4, number of transform pipeline stages; also the latency from row accept to out_valid.
LUMA_BLKS, 16, luma 4x4 blocks per macroblock.
CHROMA_BLKS, 8, chroma 4x4 blocks per macroblock (4 Cb, then 4 Cr).

Ports:
CLK  in  1  clock.
RESET  in  1  synchronous, active-low reset.
mb_start  in  1  pulse; starts a macroblock when IDLE.
chroma_en  in  1  sampled with mb_start; 1 = 24 blocks, 0 = 16 blocks.
busy  out  1  high in FEED and DRAIN.
done  out  1  one-cycle pulse when the macroblock has fully drained.
in_valid  in  1  residual row available.
in_ready  out  1  sequencer accepts a row this cycle.
blk_idx_in  out  5  block index of the row being requested (0..23).
row_idx_in  out  2  row index within the block being requested.
stage_en  out  PIPE_DEPTH  per-stage register enables; bit 0 is the first stage.
out_valid  in/out: out  1  transform result row valid at the last stage.
out_ready  in  1  downstream accepts the result row.
blk_idx_out  out  5  block tag of the output row.
row_idx_out  out  2  row tag of the output row.
is_chroma_out  out  1  blk_idx_out >= LUMA_BLKS.
blk_last_out  out  1  output row is row 3 of its block.

Behaviour:
- Reset (RESET=0 at posedge): state IDLE; counters, valid shift register and tags cleared. busy, done, in_ready, stage_en, out_valid and all tag outputs are 0. Reset mid-macroblock discards all in-flight rows with no done pulse.
- States and transitions:
  - IDLE -> FEED on mb_start. chroma_en is latched and total = 16 or 24 blocks.
  - FEED -> DRAIN on the cycle after the accept of row 3 of block total-1.
  - DRAIN -> DONE when all valid bits are 0.
  - DONE -> IDLE unconditionally.
- mb_start is ignored outside IDLE. There is no queuing.
- stall = out_valid & ~out_ready. advance = ~stall.
- in_ready = (state==FEED) & advance. accept = in_valid & in_ready.
- On accept: row counter increments 0..3. On wrap it resets to 0 and the block counter increments. blk_idx_in/row_idx_in always show the current counters. Counters are held when in_valid is low or during a stall.
- Valid/tag shift register vld[0..PIPE_DEPTH-1] with a (blk,row) tag per stage. On advance, vld[0]<=accept with the current tag, and vld[i]<=vld[i-1] with its tag. On stall, everything holds.
- stage_en[0] = accept. stage_en[i] = advance & vld[i-1] for i >= 1. All stage_en bits are 0 during a stall.
- out_valid = vld[PIPE_DEPTH-1]. The tag outputs come from the last stage. A row accepted at cycle t gives out_valid at t+PIPE_DEPTH with no stalls. Output holds stable while out_valid & ~out_ready.
- Simultaneous consume and new accept in the same cycle is allowed, giving full throughput of one row per cycle.
- done=1 only in DONE. busy=0 in DONE and IDLE. A new mb_start is honoured from the cycle after DONE.

Decomposition:
- Package h264_tx_pkg holds:
  - enum seq_state_t {IDLE, FEED, DRAIN, DONE};
  - constants LUMA_BLKS=16, CHROMA_BLKS=8, ROWS_PER_BLK=4;
  - struct tx_tag_t {blk[4:0], row[1:0]}.
- Sub-module h264_tx_tag_pipe holds the parameterised PIPE_DEPTH valid+tag shift register with an advance input. The top level holds the FSM, counters and enable logic.

Test Plan:
- Luma MB, chroma_en=0, in_valid and out_ready held high, mb_start at cycle 0 -> accepts on cycles 1..64 (blk 0..15). First out_valid at cycle 5 with tag blk=0,row=0. Last output at cycle 68 with blk=15,row=3,blk_last_out=1. done pulses at cycle 70.
- Chroma MB, chroma_en=1 -> 96 rows. blk_idx_out runs 0..23. is_chroma_out=1 exactly for blk 16..23. done pulses once.
- out_ready low for 3 cycles while out_valid=1 -> in_ready=0 and stage_en=0 for those 3 cycles, output tag unchanged, then the flow resumes with no lost or duplicated rows (scoreboard sequence 0..63).
- in_valid toggled 1-cycle on / 1-cycle off -> counters advance only on accept. out_valid shows the matching gaps. Tag order is preserved.
- mb_start pulsed during FEED and during DONE -> ignored, no extra busy period. mb_start on the first IDLE cycle after DONE -> a new macroblock starts.
- RESET=0 asserted mid-FEED at block 7 -> the next cycle has all outputs 0 and state IDLE, with no done pulse. A following mb_start restarts at blk 0,row 0.

Source files
------------

// File: rtl/h264_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | h264_tx_pkg                                                              |
// | Shared types and constants for the H.264 transform MB sequencer.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package h264_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int LUMA_BLKS    = 16;
    localparam int CHROMA_BLKS  = 8;
    localparam int ROWS_PER_BLK = 4;

    typedef struct packed {
        logic [4:0] blk;
        logic [1:0] row;
    } tx_tag_t;

endpackage
`default_nettype wire

// File: rtl/h264_tx_tag_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | h264_tx_tag_pipe                                                         |
// | Valid + (block,row) tag shift register tracking rows through the         |
// | transform stages; the whole chain holds when advance is low.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module h264_tx_tag_pipe
    import h264_tx_pkg::*;
#(
    parameter int PIPE_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  i_advance,
    input  logic                  i_accept,
    input  logic [4:0]            i_blk,
    input  logic [1:0]            i_row,
    output logic [PIPE_DEPTH-1:0] o_vld,
    output logic [4:0]            o_blk,
    output logic [1:0]            o_row
);

    logic    [PIPE_DEPTH-1:0] r_vld;
    tx_tag_t [PIPE_DEPTH-1:0] r_tag;

    // Empty slots carry a zero tag so the outputs stay clean between rows.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_vld <= '0;
            r_tag <= '0;
        end else if (i_advance) begin
            r_vld[0] <= i_accept;
            r_tag[0] <= i_accept ? tx_tag_t'({i_blk, i_row}) : tx_tag_t'('0);
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_vld = r_vld;
    assign o_blk = r_tag[PIPE_DEPTH-1].blk;
    assign o_row = r_tag[PIPE_DEPTH-1].row;

endmodule
`default_nettype wire

// File: rtl/h264_transform_mb_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | h264_transform_mb_sequencer                                              |
// | Stall-safe, tag-tracked row scheduler for the 4-stage core transform.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module h264_transform_mb_sequencer #(
    parameter int PIPE_DEPTH  = 4,
    parameter int LUMA_BLKS   = 16,
    parameter int CHROMA_BLKS = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  i_mb_start,
    input  logic                  i_chroma_en,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic [4:0]            o_blk_idx_in,
    output logic [1:0]            o_row_idx_in,
    output logic [PIPE_DEPTH-1:0] o_stage_en,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [4:0]            o_blk_idx_out,
    output logic [1:0]            o_row_idx_out,
    output logic                  o_is_chroma_out,
    output logic                  o_blk_last_out
);

    import h264_tx_pkg::*;

    seq_state_t            r_state;
    seq_state_t            w_state_nxt;
    logic                  r_chroma;
    logic [4:0]            r_blk;
    logic [1:0]            r_row;
    logic [PIPE_DEPTH-1:0] w_vld;
    logic [4:0]            w_total;
    logic                  w_stall;
    logic                  w_advance;
    logic                  w_accept;
    logic                  w_last_row;

    assign w_stall    = o_out_valid & ~i_out_ready;
    assign w_advance  = ~w_stall;
    assign w_accept   = i_in_valid & o_in_ready;
    assign w_total    = r_chroma ? 5'(LUMA_BLKS + CHROMA_BLKS) : 5'(LUMA_BLKS);
    assign w_last_row = w_accept && (r_row == 2'(ROWS_PER_BLK - 1))
                        && (r_blk == w_total - 5'd1);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_mb_start) w_state_nxt = FEED;
            FEED:    if (w_last_row) w_state_nxt = DRAIN;
            DRAIN:   if (w_vld == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_in_ready = 1'b0;
        case (r_state)
            FEED: begin
                o_busy     = 1'b1;
                o_in_ready = w_advance;
            end
            DRAIN:   o_busy = 1'b1;
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    // Row/block counters restart on each honoured mb_start.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_chroma <= 1'b0;
            r_blk    <= '0;
            r_row    <= '0;
        end else if ((r_state == IDLE) && i_mb_start) begin
            r_chroma <= i_chroma_en;
            r_blk    <= '0;
            r_row    <= '0;
        end else if (w_accept) begin
            r_row <= r_row + 2'd1;
            if (r_row == 2'(ROWS_PER_BLK - 1)) begin
                r_blk <= r_blk + 5'd1;
            end
        end
    end

    assign o_blk_idx_in = r_blk;
    assign o_row_idx_in = r_row;

    h264_tx_tag_pipe #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_tag_pipe (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_advance (w_advance),
        .i_accept  (w_accept),
        .i_blk     (r_blk),
        .i_row     (r_row),
        .o_vld     (w_vld),
        .o_blk     (o_blk_idx_out),
        .o_row     (o_row_idx_out)
    );

    always_comb begin
        o_stage_en    = '0;
        o_stage_en[0] = w_accept;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            o_stage_en[i] = w_advance & w_vld[i-1];
        end
    end

    assign o_out_valid     = w_vld[PIPE_DEPTH-1];
    assign o_is_chroma_out = (o_blk_idx_out >= 5'(LUMA_BLKS));
    assign o_blk_last_out  = (o_row_idx_out == 2'(ROWS_PER_BLK - 1));

endmodule
`default_nettype wire

// File: tb/tb_h264_transform_mb_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_h264_transform_mb_sequencer                                           |
// | Directed bench with a row-queue reference model and literal pins.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_h264_transform_mb_sequencer;

    localparam int DEPTH = 4;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             i_mb_start = 1'b0;
    logic             i_chroma_en = 1'b0;
    logic             i_in_valid = 1'b0;
    logic             i_out_ready = 1'b1;
    logic             o_busy, o_done, o_in_ready, o_out_valid;
    logic [4:0]       o_blk_idx_in, o_blk_idx_out;
    logic [1:0]       o_row_idx_in, o_row_idx_out;
    logic [DEPTH-1:0] o_stage_en;
    logic             o_is_chroma_out, o_blk_last_out;

    h264_transform_mb_sequencer #(
        .PIPE_DEPTH  (DEPTH),
        .LUMA_BLKS   (16),
        .CHROMA_BLKS (8)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .i_mb_start      (i_mb_start),
        .i_chroma_en     (i_chroma_en),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .i_in_valid      (i_in_valid),
        .o_in_ready      (o_in_ready),
        .o_blk_idx_in    (o_blk_idx_in),
        .o_row_idx_in    (o_row_idx_in),
        .o_stage_en      (o_stage_en),
        .o_out_valid     (o_out_valid),
        .i_out_ready     (i_out_ready),
        .o_blk_idx_out   (o_blk_idx_out),
        .o_row_idx_out   (o_row_idx_out),
        .o_is_chroma_out (o_is_chroma_out),
        .o_blk_last_out  (o_blk_last_out)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase of the macroblock plus a queue of in-flight rows,
    // each aging once per non-stalled cycle and visible at age DEPTH.
    typedef struct { int blk; int row; int age; } ent_t;
    ent_t q[$];
    int   m_phase = 0;   // 0 idle, 1 feeding, 2 draining, 3 done
    int   m_total = 0;
    int   m_acc   = 0;
    bit   m_live  = 1'b0;
    int   cyc     = 0;

    // Observations of the DUT, reset at each honoured mb_start.
    int s_cyc, first_ov, first_blk, first_row, last_out, last_blk, last_row, last_blast;
    int done_cnt, done_cyc, cons, chroma_cnt, max_blk, stall_ok;

    always begin : monitor
        bit ov, stall, ir, acc;
        logic [DEPTH-1:0] en;
        @(negedge CLK);
        cyc++;
        ov    = (q.size() > 0) && (q[0].age == DEPTH);
        stall = ov && !i_out_ready;
        ir    = (m_phase == 1) && !stall;
        acc   = i_in_valid && ir;
        en    = '0;
        en[0] = acc;
        foreach (q[i]) if (!stall && q[i].age >= 1 && q[i].age < DEPTH) en[q[i].age] = 1'b1;

        if (m_live) begin
            chk("busy", 32'(o_busy), 32'(m_phase == 1 || m_phase == 2));
            chk("done", 32'(o_done), 32'(m_phase == 3));
            chk("in_ready", 32'(o_in_ready), 32'(ir));
            chk("blk_idx_in", 32'(o_blk_idx_in), 32'(m_acc / 4));
            chk("row_idx_in", 32'(o_row_idx_in), 32'(m_acc % 4));
            chk("stage_en", 32'(o_stage_en), 32'(en));
            chk("out_valid", 32'(o_out_valid), 32'(ov));
            if (ov) begin
                chk("blk_idx_out", 32'(o_blk_idx_out), 32'(q[0].blk));
                chk("row_idx_out", 32'(o_row_idx_out), 32'(q[0].row));
                chk("is_chroma_out", 32'(o_is_chroma_out), 32'(q[0].blk >= 16));
                chk("blk_last_out", 32'(o_blk_last_out), 32'(q[0].row == 3));
            end
            if (o_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (o_out_valid === 1'b1 && first_ov < 0) begin
                first_ov  = cyc;
                first_blk = int'(o_blk_idx_out);
                first_row = int'(o_row_idx_out);
            end
            if (o_out_valid === 1'b1 && !i_out_ready && o_in_ready === 1'b0 && o_stage_en === '0)
                stall_ok++;
            if (o_out_valid === 1'b1 && i_out_ready) begin
                cons++;
                if (o_is_chroma_out === 1'b1) chroma_cnt++;
                if (int'(o_blk_idx_out) > max_blk) max_blk = int'(o_blk_idx_out);
                last_out   = cyc;
                last_blk   = int'(o_blk_idx_out);
                last_row   = int'(o_row_idx_out);
                last_blast = int'(o_blk_last_out);
            end
        end

        // Advance the model to the state after the coming clock edge.
        if (!RESET) begin
            q.delete();
            m_phase = 0;
            m_acc   = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            case (m_phase)
                0: if (i_mb_start) begin
                    m_phase = 1;
                    m_total = i_chroma_en ? 96 : 64;
                    m_acc   = 0;
                    s_cyc = cyc; first_ov = -1; done_cnt = 0; done_cyc = -1;
                    cons = 0; chroma_cnt = 0; max_blk = -1; stall_ok = 0; last_out = -1;
                end
                2: if (q.size() == 0) m_phase = 3;
                3: m_phase = 0;
                default: ;
            endcase
            if (!stall) begin
                if (ov) void'(q.pop_front());
                foreach (q[i]) q[i].age++;
                if (acc) q.push_back('{m_acc / 4, m_acc % 4, 1});
            end
            if (acc) begin
                m_acc++;
                if (m_acc == m_total) m_phase = 2;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Start one macroblock and feed it until done is seen (cycle S+k gets index k).
    task automatic drive_mb(input bit chroma, input bit toggle, input int stall_at, input int poke_at);
        i_mb_start  = 1'b1;
        i_chroma_en = chroma;
        i_in_valid  = 1'b1;
        i_out_ready = 1'b1;
        tick();
        i_mb_start  = 1'b0;
        i_chroma_en = 1'b0;
        for (int k = 1; k < 400; k++) begin
            i_in_valid  = toggle ? 1'(k % 2) : 1'b1;
            i_out_ready = !(stall_at > 0 && k >= stall_at && k < stall_at + 3);
            i_mb_start  = (k == poke_at);
            tick();
            if (o_done === 1'b1) begin
                i_mb_start = 1'b0;
                return;
            end
        end
        i_mb_start = 1'b0;
        chk("done_timeout", 32'(o_done), 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin : stim
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_stage_en", 32'(o_stage_en), 32'd0);
        chk("rst_blk_out", 32'(o_blk_idx_out), 32'd0);
        tick();

        // Luma, full throughput.
        drive_mb(1'b0, 1'b0, 0, 0);
        tick();
        chk("t1_first_ov_lat", 32'(first_ov - s_cyc), 32'd5);
        chk("t1_first_tag", 32'({first_blk[4:0], first_row[1:0]}), 32'd0);
        chk("t1_last_out_lat", 32'(last_out - s_cyc), 32'd68);
        chk("t1_last_tag", 32'({last_blk[4:0], last_row[1:0], last_blast[0]}), 32'({5'd15, 2'd3, 1'b1}));
        chk("t1_done_lat", 32'(done_cyc - s_cyc), 32'd70);
        chk("t1_rows", 32'(cons), 32'd64);
        tick();

        // Chroma macroblock.
        drive_mb(1'b1, 1'b0, 0, 0);
        tick();
        chk("t2_rows", 32'(cons), 32'd96);
        chk("t2_chroma_rows", 32'(chroma_cnt), 32'd32);
        chk("t2_max_blk", 32'(max_blk), 32'd23);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);

        // Three-cycle downstream stall mid-stream.
        drive_mb(1'b0, 1'b0, 20, 0);
        tick();
        chk("t3_stall_cycles", 32'(stall_ok), 32'd3);
        chk("t3_rows", 32'(cons), 32'd64);
        chk("t3_done_lat", 32'(done_cyc - s_cyc), 32'd73);

        // Input valid toggling every cycle.
        drive_mb(1'b0, 1'b1, 0, 0);
        tick();
        chk("t4_rows", 32'(cons), 32'd64);
        chk("t4_done_lat", 32'(done_cyc - s_cyc), 32'd133);

        // mb_start during FEED and DONE is ignored; first IDLE cycle restarts.
        drive_mb(1'b0, 1'b0, 0, 10);
        i_mb_start = 1'b1;
        tick();
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);
        chk("t5_idle_after_done", 32'(o_busy), 32'd0);
        drive_mb(1'b0, 1'b0, 0, 0);
        tick();
        chk("t5_restart_rows", 32'(cons), 32'd64);
        chk("t5_restart_done_lat", 32'(done_cyc - s_cyc), 32'd70);

        // Reset mid-FEED at block 7.
        i_mb_start = 1'b1;
        i_in_valid = 1'b1;
        i_out_ready = 1'b1;
        tick();
        i_mb_start = 1'b0;
        for (int k = 0; k < 100 && o_blk_idx_in !== 5'd7; k++) tick();
        chk("t6_reached_blk7", 32'(o_blk_idx_in), 32'd7);
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        chk("t6_busy", 32'(o_busy), 32'd0);
        chk("t6_in_ready", 32'(o_in_ready), 32'd0);
        chk("t6_stage_en", 32'(o_stage_en), 32'd0);
        chk("t6_out_valid", 32'(o_out_valid), 32'd0);
        chk("t6_tags_out", 32'({o_blk_idx_out, o_row_idx_out, o_is_chroma_out, o_blk_last_out}), 32'd0);
        chk("t6_tags_in", 32'({o_blk_idx_in, o_row_idx_in}), 32'd0);
        tick();
        tick();
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        drive_mb(1'b0, 1'b0, 0, 0);
        tick();
        chk("t6_restart_first_tag", 32'({first_blk[4:0], first_row[1:0]}), 32'd0);
        chk("t6_restart_rows", 32'(cons), 32'd64);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
